// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing constant sets, width defaults and pattern helper
package vga_pkg;

    localparam int DEF_CNT_W = 11;
    localparam int DEF_RGB_W = 12;

    typedef struct packed {
        int unsigned h_disp;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_disp;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
        int unsigned pclk_khz;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60  = '{640,  16,  96,  48, 480, 10, 2, 33, 25000};
    localparam vga_timing_t VGA_800X600_72  = '{800,  56, 120,  64, 600, 37, 6, 23, 50000};
    localparam vga_timing_t VGA_1024X768_60 = '{1024, 24, 136, 160, 768,  3, 6, 29, 65000};

    // Colour-bar index: the display width is split into eight equal bars.
    function automatic int bar_index(input int x, input int disp);
        return (x * 8) / disp;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// rtl/vga_timing_ctrl_if.sv - pixel-source request/data interface
interface vga_timing_ctrl_if #(
    parameter int CNT_W = 11,
    parameter int RGB_W = 12
);
    logic             vga_req;
    logic [CNT_W-1:0] vga_xpos;
    logic [CNT_W-1:0] vga_ypos;
    logic [RGB_W-1:0] vga_data;

    modport master (output vga_req, output vga_xpos, output vga_ypos, input vga_data);
    modport slave  (input vga_req, input vga_xpos, input vga_ypos, output vga_data);
endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - reset-valued shift register; DEPTH 0 is a plain wire
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA timing generator; VGA_TEST_PATTERN_EN adds colour bars
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RGB_W   = DEF_RGB_W,
    parameter int RD_LAT  = 1,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0
) (
    input  logic               clk_vga,
    input  logic               rst_n,
    vga_timing_ctrl_if.master  src,
    input  logic               pat_en,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic [RGB_W-1:0]   vga_rgb,
    output logic               vga_sof,
    output logic               vga_sol
);

    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic h_wrap, v_wrap, h_act, v_act;
    logic raw_de, raw_hs, raw_vs, raw_sof, raw_sol;
    logic d_de, d_hs, d_vs, d_sof, d_sol;
    logic [RGB_W-1:0] pix;

    assign h_wrap = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_wrap = (v_cnt == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end
    end

    assign h_act = (h_cnt < CNT_W'(H_DISP));
    assign v_act = (v_cnt < CNT_W'(V_DISP));

    assign src.vga_req  = h_act & v_act;
    assign src.vga_xpos = src.vga_req ? h_cnt : '0;
    assign src.vga_ypos = src.vga_req ? v_cnt : '0;

    assign raw_de  = src.vga_req;
    assign raw_hs  = (h_cnt >= CNT_W'(H_DISP + H_FRONT) && h_cnt < CNT_W'(H_DISP + H_FRONT + H_SYNC))
                     ? HS_POL : ~HS_POL;
    assign raw_vs  = (v_cnt >= CNT_W'(V_DISP + V_FRONT) && v_cnt < CNT_W'(V_DISP + V_FRONT + V_SYNC))
                     ? VS_POL : ~VS_POL;
    assign raw_sof = (h_cnt == '0) && (v_cnt == '0);
    assign raw_sol = (h_cnt == '0) && v_act;

    // Control bits travel alongside the source read so they line up with vga_data.
    localparam logic [4:0] CTRL_RST = {1'b0, ~HS_POL, ~VS_POL, 2'b00};

`ifdef VGA_TEST_PATTERN_EN
    localparam int              LW       = 5 + CNT_W;
    localparam logic [LW-1:0]   LINE_RST = {CTRL_RST, {CNT_W{1'b0}}};
    localparam int              CH_W     = RGB_W / 3;

    logic [LW-1:0]    line_in, line_out;
    logic [CNT_W-1:0] d_xpos;
    logic [2:0]       bar;
    logic [RGB_W-1:0] pat_rgb;

    assign line_in = {raw_de, raw_hs, raw_vs, raw_sof, raw_sol, src.vga_xpos};
    assign {d_de, d_hs, d_vs, d_sof, d_sol, d_xpos} = line_out;

    assign bar     = 3'(bar_index(int'(d_xpos), H_DISP));
    assign pat_rgb = RGB_W'({{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}});
    assign pix     = pat_en ? pat_rgb : src.vga_data;
`else
    localparam int            LW       = 5;
    localparam logic [LW-1:0] LINE_RST = CTRL_RST;

    logic [LW-1:0] line_in, line_out;
    logic          unused_pat_en;

    assign line_in = {raw_de, raw_hs, raw_vs, raw_sof, raw_sol};
    assign {d_de, d_hs, d_vs, d_sof, d_sol} = line_out;
    assign unused_pat_en = pat_en;
    assign pix = src.vga_data;
`endif

    vga_delay_line #(
        .WIDTH   (LW),
        .DEPTH   (RD_LAT),
        .RST_VAL (LINE_RST)
    ) u_delay (
        .clk   (clk_vga),
        .rst_n (rst_n),
        .din   (line_in),
        .dout  (line_out)
    );

    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            vga_hs  <= ~HS_POL;
            vga_vs  <= ~VS_POL;
            vga_de  <= 1'b0;
            vga_sof <= 1'b0;
            vga_sol <= 1'b0;
            vga_rgb <= '0;
        end else begin
            vga_hs  <= d_hs;
            vga_vs  <= d_vs;
            vga_de  <= d_de;
            vga_sof <= d_sof;
            vga_sol <= d_sol;
            vga_rgb <= d_de ? pix : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - self-checking bench for vga_timing_ctrl on a 16x8 timing set
module tb_vga_timing_ctrl;

    localparam int CW = 11;
    localparam int RW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n  = 1'b0;
    logic pat_en = 1'b0;

    vga_timing_ctrl_if #(.CNT_W(CW), .RGB_W(RW)) src  ();
    vga_timing_ctrl_if #(.CNT_W(CW), .RGB_W(RW)) src0 ();
    vga_timing_ctrl_if #(.CNT_W(CW), .RGB_W(RW)) src4 ();

    logic vga_hs, vga_vs, vga_de, vga_sof, vga_sol;
    logic [RW-1:0] vga_rgb;
    logic hs0, vs0, de0, sof0, sol0;
    logic [RW-1:0] rgb0;
    logic hs4, vs4, de4, sof4, sol4;
    logic [RW-1:0] rgb4;

    vga_timing_ctrl #(
        .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CNT_W(CW), .RGB_W(RW), .RD_LAT(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk_vga(clk), .rst_n(rst_n), .src(src), .pat_en(pat_en),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
        .vga_sof(vga_sof), .vga_sol(vga_sol)
    );

    vga_timing_ctrl #(
        .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CNT_W(CW), .RGB_W(RW), .RD_LAT(0), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut0 (
        .clk_vga(clk), .rst_n(rst_n), .src(src0), .pat_en(pat_en),
        .vga_hs(hs0), .vga_vs(vs0), .vga_de(de0), .vga_rgb(rgb0),
        .vga_sof(sof0), .vga_sol(sol0)
    );

    vga_timing_ctrl #(
        .H_DISP(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISP(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CNT_W(CW), .RGB_W(RW), .RD_LAT(4), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut4 (
        .clk_vga(clk), .rst_n(rst_n), .src(src4), .pat_en(pat_en),
        .vga_hs(hs4), .vga_vs(vs4), .vga_de(de4), .vga_rgb(rgb4),
        .vga_sof(sof4), .vga_sol(sol4)
    );

    typedef struct {
        bit          de;
        bit          hs;
        bit          vs;
        bit          sof;
        bit          sol;
        logic [RW-1:0] rgb;
    } exp_t;

    typedef struct {
        int cyc;
        bit req;
        bit de;
        bit hs_act;
        bit sof;
        bit sol;
    } vec_t;

    exp_t sb[$];
    vec_t tab[12];

    int checks = 0;
    int errors = 0;
    int cyc, mh, mv;
    int first_de0 = -1;
    int first_de4 = -1;
    int sof_n, sol_n, vs_act, sof_at;
    logic [RW-1:0] pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_pix(input int x, input int y);
        logic [RW-1:0] v;
        v = RW'(x + 16 * y);
`ifdef VGA_TEST_PATTERN_EN
        if (pat_en) begin
            int b;
            b = (x * 8) / 8;
            v = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
        end
`endif
        return v;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_hs"},   32'(vga_hs),  32'd1);
        chk({tag, "_vs"},   32'(vga_vs),  32'd1);
        chk({tag, "_de"},   32'(vga_de),  32'd0);
        chk({tag, "_sof"},  32'(vga_sof), 32'd0);
        chk({tag, "_sol"},  32'(vga_sol), 32'd0);
        chk({tag, "_rgb"},  32'(vga_rgb), 32'd0);
        chk({tag, "_req"},  32'(src.vga_req),  32'd1);
        chk({tag, "_xpos"}, 32'(src.vga_xpos), 32'd0);
    endtask

    // Release reset at a negedge: that sample is cycle 0 and the first two
    // output samples still carry reset values.
    task automatic start();
        exp_t r;
        rst_n = 1'b1;
        cyc = 0; mh = 0; mv = 0;
        pend = '0;
        src.vga_data = '0;
        r = '{de: 1'b0, hs: 1'b1, vs: 1'b1, sof: 1'b0, sol: 1'b0, rgb: '0};
        sb.delete();
        sb.push_back(r);
        sb.push_back(r);
    endtask

    task automatic step();
        bit   req_e;
        exp_t e, o;
        req_e = (mh < 8) && (mv < 4);
        chk("req",  32'(src.vga_req),  32'(req_e));
        chk("xpos", 32'(src.vga_xpos), req_e ? 32'(mh) : 32'd0);
        chk("ypos", 32'(src.vga_ypos), req_e ? 32'(mv) : 32'd0);

        e.de  = req_e;
        e.hs  = !(mh >= 10 && mh < 13);
        e.vs  = !(mv >= 5 && mv < 7);
        e.sof = (mh == 0) && (mv == 0);
        e.sol = (mh == 0) && (mv < 4);
        e.rgb = req_e ? exp_pix(mh, mv) : '0;
        sb.push_back(e);
        if (sb.size() == 3) begin
            o = sb.pop_front();
            chk("de",  32'(vga_de),  32'(o.de));
            chk("hs",  32'(vga_hs),  32'(o.hs));
            chk("vs",  32'(vga_vs),  32'(o.vs));
            chk("sof", 32'(vga_sof), 32'(o.sof));
            chk("sol", 32'(vga_sol), 32'(o.sol));
            chk("rgb", 32'(vga_rgb), 32'(o.rgb));
        end

        // Pixel source with one cycle of read latency.
        src.vga_data = pend;
        pend = src.vga_req ? RW'(src.vga_xpos + 16 * src.vga_ypos) : '0;

        if (vga_sof) begin sof_n++; sof_at = cyc; end
        if (vga_sol) sol_n++;
        if (!vga_vs) vs_act++;
        if (first_de0 < 0 && de0) first_de0 = cyc;
        if (first_de4 < 0 && de4) first_de4 = cyc;

        mh++;
        if (mh == 16) begin
            mh = 0;
            mv = (mv == 7) ? 0 : mv + 1;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        tab[0]  = '{0,  1, 0, 0, 0, 0};
        tab[1]  = '{1,  1, 0, 0, 0, 0};
        tab[2]  = '{2,  1, 1, 0, 1, 1};
        tab[3]  = '{3,  1, 1, 0, 0, 0};
        tab[4]  = '{7,  1, 1, 0, 0, 0};
        tab[5]  = '{8,  0, 1, 0, 0, 0};
        tab[6]  = '{9,  0, 1, 0, 0, 0};
        tab[7]  = '{10, 0, 0, 0, 0, 0};
        tab[8]  = '{12, 0, 0, 1, 0, 0};
        tab[9]  = '{14, 0, 0, 1, 0, 0};
        tab[10] = '{15, 0, 0, 0, 0, 0};
        tab[11] = '{18, 1, 1, 0, 0, 1};

        cyc = 0;
        src.vga_data  = '0;
        src0.vga_data = '0;
        src4.vga_data = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("init");

        start();
        foreach (tab[i]) begin
            while (cyc < tab[i].cyc) step();
            chk("tab_req",    32'(src.vga_req), 32'(tab[i].req));
            chk("tab_de",     32'(vga_de),      32'(tab[i].de));
            chk("tab_hs_act", 32'(vga_hs == 1'b0), 32'(tab[i].hs_act));
            chk("tab_sof",    32'(vga_sof),     32'(tab[i].sof));
            chk("tab_sol",    32'(vga_sol),     32'(tab[i].sol));
        end
        chk("lat0_first_de", 32'(first_de0), 32'd1);
        chk("lat4_first_de", 32'(first_de4), 32'd5);

        // Mid-frame reset at cycle 37, held for two edges.
        while (cyc < 37) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midrst1");
        @(negedge clk);
        chk_reset("midrst2");

        start();
        for (int f = 0; f < 2; f++) begin
            sof_n = 0; sol_n = 0; vs_act = 0; sof_at = -1;
            if (f == 1) pat_en = 1'b1;
            for (int c = 0; c < 128; c++) step();
            chk("frame_sof_n",     32'(sof_n),  32'd1);
            chk("frame_sof_pos",   32'(sof_at), 32'(128 * f + 2));
            chk("frame_sol_n",     32'(sol_n),  32'd4);
            chk("frame_vs_cycles", 32'(vs_act), 32'd32);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
